// File: rtl/cpu_mul_pkg.sv
// Shared types and helpers for the pipelined CPU multiplier.
// Mode encoding matches the CPU's in_mode field.
package cpu_mul_pkg;

    localparam int unsigned DATA_W_DEF = 32;
    localparam int unsigned PART_W_DEF = 16;
    localparam int unsigned NLIMB      = DATA_W_DEF / PART_W_DEF;

    typedef enum logic [1:0] {
        MODE_MUL    = 2'd0,
        MODE_MULXUU = 2'd1,
        MODE_MULXSU = 2'd2,
        MODE_MULXSS = 2'd3
    } mode_e;

    typedef struct packed {
        logic a_signed;
        logic b_signed;
    } sign_t;

    // MUL takes the unsigned path: the low word does not depend on signedness.
    function automatic sign_t mode_sign(input mode_e m);
        sign_t s;
        s.a_signed = (m == MODE_MULXSU) || (m == MODE_MULXSS);
        s.b_signed = (m == MODE_MULXSS);
        return s;
    endfunction

endpackage

// File: rtl/cpu_mul_limb.sv
// Registered unsigned PART_W x PART_W limb multiplier with enable and
// synchronous clear.
module cpu_mul_limb #(
    parameter int unsigned PART_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_en,
    input  logic                  i_clr,
    input  logic [PART_W-1:0]     i_a,
    input  logic [PART_W-1:0]     i_b,
    output logic [2*PART_W-1:0]   o_p
);

    logic [2*PART_W-1:0] r_p;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_p <= '0;
        end else if (i_en) begin
            r_p <= {{PART_W{1'b0}}, i_a} * {{PART_W{1'b0}}, i_b};
        end
    end

    assign o_p = r_p;

endmodule

// File: rtl/cpu_mul_pipe.sv
// Three-stage pipelined multiplier (operands -> limb products -> sum) with
// valid/ready handshake, global stall, flush and tag passthrough.
module cpu_mul_pipe #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned PART_W = 16,
    parameter int unsigned TAG_W  = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_a,
    input  logic [DATA_W-1:0]     in_b,
    input  logic [1:0]            in_mode,
    input  logic [TAG_W-1:0]      in_tag,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_result,
    output logic [2*DATA_W-1:0]   out_full,
    output logic [TAG_W-1:0]      out_tag
);

    import cpu_mul_pkg::*;

    localparam int unsigned NL  = DATA_W / PART_W;
    localparam int unsigned NP  = NL * NL;
    localparam int unsigned PW2 = 2 * PART_W;
    localparam int unsigned FW  = 2 * DATA_W;

    if (DATA_W % PART_W != 0) begin : g_width_check
        $error("cpu_mul_pipe: DATA_W must be a multiple of PART_W");
    end

    logic                 w_adv;

    logic                 r_s1_valid;
    logic [DATA_W-1:0]    r_s1_a;
    logic [DATA_W-1:0]    r_s1_b;
    mode_e                r_s1_mode;
    logic [TAG_W-1:0]     r_s1_tag;

    logic                 r_s2_valid;
    mode_e                r_s2_mode;
    logic [TAG_W-1:0]     r_s2_tag;
    logic [DATA_W-1:0]    r_s2_corr;

    logic                 r_s3_valid;
    logic [DATA_W-1:0]    r_s3_result;
    logic [FW-1:0]        r_s3_full;
    logic [TAG_W-1:0]     r_s3_tag;

    sign_t                w_s1_sign;
    logic [DATA_W-1:0]    w_corr;
    logic [PW2-1:0]       w_prod [NP];
    logic [FW-1:0]        w_sum;
    logic [FW-1:0]        w_full;

    assign w_adv    = ~r_s3_valid | out_ready;
    assign in_ready = w_adv & ~flush & ~reset;

    // Stage 1: operand capture
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_a     <= '0;
            r_s1_b     <= '0;
            r_s1_mode  <= MODE_MUL;
            r_s1_tag   <= '0;
        end else if (flush) begin
            r_s1_valid <= 1'b0;
        end else if (w_adv) begin
            r_s1_valid <= in_valid;
            r_s1_a     <= in_a;
            r_s1_b     <= in_b;
            r_s1_mode  <= mode_e'(in_mode);
            r_s1_tag   <= in_tag;
        end
    end

    // Sign correction only touches the upper word, so only that half is kept.
    always_comb begin
        w_s1_sign = mode_sign(r_s1_mode);
        w_corr    = '0;
        if (w_s1_sign.a_signed && r_s1_a[DATA_W-1]) begin
            w_corr = w_corr + r_s1_b;
        end
        if (w_s1_sign.b_signed && r_s1_b[DATA_W-1]) begin
            w_corr = w_corr + r_s1_a;
        end
    end

    // Stage 2: limb products
    for (genvar gi = 0; gi < NL; gi++) begin : g_row
        for (genvar gj = 0; gj < NL; gj++) begin : g_col
            cpu_mul_limb #(
                .PART_W (PART_W)
            ) u_limb (
                .i_clk (clk),
                .i_en  (w_adv),
                .i_clr (reset),
                .i_a   (r_s1_a[gi*PART_W +: PART_W]),
                .i_b   (r_s1_b[gj*PART_W +: PART_W]),
                .o_p   (w_prod[gi*NL + gj])
            );
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_valid <= 1'b0;
            r_s2_mode  <= MODE_MUL;
            r_s2_tag   <= '0;
            r_s2_corr  <= '0;
        end else if (flush) begin
            r_s2_valid <= 1'b0;
        end else if (w_adv) begin
            r_s2_valid <= r_s1_valid;
            r_s2_mode  <= r_s1_mode;
            r_s2_tag   <= r_s1_tag;
            r_s2_corr  <= w_corr;
        end
    end

    always_comb begin
        w_sum = '0;
        for (int unsigned i = 0; i < NL; i++) begin
            for (int unsigned j = 0; j < NL; j++) begin
                w_sum = w_sum + (FW'(w_prod[i*NL + j]) << (PART_W * (i + j)));
            end
        end
        w_full = w_sum - {r_s2_corr, {DATA_W{1'b0}}};
    end

    // Stage 3: summed product and word select
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s3_valid  <= 1'b0;
            r_s3_result <= '0;
            r_s3_full   <= '0;
            r_s3_tag    <= '0;
        end else if (flush) begin
            r_s3_valid <= 1'b0;
        end else if (w_adv) begin
            r_s3_valid  <= r_s2_valid;
            r_s3_full   <= w_full;
            r_s3_tag    <= r_s2_tag;
            r_s3_result <= (r_s2_mode == MODE_MUL) ? w_full[DATA_W-1:0] : w_full[FW-1:DATA_W];
        end
    end

    assign out_valid  = r_s3_valid;
    assign out_result = r_s3_result;
    assign out_full   = r_s3_full;
    assign out_tag    = r_s3_tag;

endmodule
